// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian 32-bit words from a byte stream and
// writes them to consecutive word addresses of the instruction memory,
// holding the CPU off until the whole program has been written.
module imem_loader #(
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [DEPTH_LOG2:0]   Word_count,
   input  logic [7:0]            Byte_in,
   input  logic                  Byte_valid,
   output logic                  Byte_ready,
   output logic                  Mem_we,
   output logic [31:0]           Mem_addr,
   output logic [31:0]           Mem_din,
   output logic                  Cpu_hold,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Err
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   // Largest legal count is the full memory depth
   localparam logic [DEPTH_LOG2:0] MAX_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   state_t                state, state_nxt;
   logic [DEPTH_LOG2:0]   count_q;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic [1:0]            byte_cnt;
   logic [23:0]           word_q;     // first three bytes; the 4th goes straight to Mem_din
   logic                  legal;
   logic                  accept;
   logic                  last_word;

   assign legal     = (Word_count != '0) && (Word_count <= MAX_CNT);
   assign accept    = (state == RECV) && Byte_valid;
   assign last_word = ({1'b0, word_idx} == (count_q - 1'b1));
   assign Busy      = (state != IDLE);
   assign Cpu_hold  = Busy;

   // State register; async reset drops Busy/Cpu_hold immediately
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-state strobes
   always_comb begin
      state_nxt  = state;
      Byte_ready = 1'b0;
      Mem_we     = 1'b0;
      Done       = 1'b0;
      case (state)
         IDLE:  if (Start && legal) state_nxt = RECV;
         RECV: begin
            Byte_ready = 1'b1;
            if (Byte_valid && byte_cnt == 2'd3) state_nxt = WRITE;
         end
         WRITE: begin
            Mem_we    = 1'b1;
            state_nxt = last_word ? DONE : RECV;
         end
         DONE: begin
            Done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters, byte assembly and the write port registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_q  <= '0;
         word_idx <= '0;
         byte_cnt <= '0;
         word_q   <= '0;
         Mem_addr <= '0;
         Mem_din  <= '0;
         Err      <= 1'b0;
      end else begin
         Err <= (state == IDLE) && Start && !legal;
         if (state == IDLE && Start && legal) begin
            count_q  <= Word_count;
            word_idx <= '0;
            byte_cnt <= '0;
         end
         if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            word_q   <= {word_q[15:0], Byte_in};
            // Load the write port on the 4th byte so it is stable through WRITE
            if (byte_cnt == 2'd3) begin
               Mem_din  <= {word_q, Byte_in};
               Mem_addr <= {{(30-DEPTH_LOG2){1'b0}}, word_idx, 2'b00};
            end
         end
         if (state == WRITE && !last_word) word_idx <= word_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: writes are captured by a monitor and
// compared against hand-computed address/data pairs.
module tb_imem_loader;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [5:0]  Word_count = '0;
   logic [7:0]  Byte_in = '0;
   logic        Byte_valid = 1'b0;
   logic        Byte_ready, Mem_we, Cpu_hold, Busy, Done, Err;
   logic [31:0] Mem_addr, Mem_din;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          n_done = 0;
   int          n_hold_bad = 0;

   imem_loader #(.DEPTH_LOG2(5)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Word_count(Word_count),
      .Byte_in(Byte_in), .Byte_valid(Byte_valid), .Byte_ready(Byte_ready),
      .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_din(Mem_din),
      .Cpu_hold(Cpu_hold), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   // Capture every write, Done pulse and hold/busy disagreement
   always @(negedge Clk) begin
      if (Mem_we) begin
         wa.push_back(Mem_addr);
         wd.push_back(Mem_din);
      end
      if (Done) n_done++;
      if (Cpu_hold !== Busy) n_hold_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was taken
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      Byte_in    = b;
      Byte_valid = 1'b1;
      while (!Byte_ready && t < 50) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 50) chk("byte_ready_timeout", 32'(t), 32'd0);
      @(negedge Clk);
      Byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge Clk);
         send_byte(w[31-8*i -: 8]);
      end
   endtask

   task automatic start(input logic [5:0] n);
      Start      = 1'b1;
      Word_count = n;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (!Done && t < 400) begin
         @(negedge Clk);
         t++;
      end
      chk("done_seen", {31'd0, Done}, 32'd1);
   endtask

   task automatic chk_write(input int idx, input logic [31:0] a, input logic [31:0] d);
      if (idx < wa.size()) begin
         chk($sformatf("wr%0d_addr", idx), wa[idx], a);
         chk($sformatf("wr%0d_data", idx), wd[idx], d);
      end else begin
         chk($sformatf("wr%0d_missing", idx), 32'(wa.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      int base, dbase;

      // Reset values
      @(negedge Clk);
      chk("rst_ready", {31'd0, Byte_ready}, 0);
      chk("rst_we",    {31'd0, Mem_we}, 0);
      chk("rst_hold",  {31'd0, Cpu_hold}, 0);
      chk("rst_busy",  {31'd0, Busy}, 0);
      chk("rst_done",  {31'd0, Done}, 0);
      chk("rst_err",   {31'd0, Err}, 0);
      chk("rst_addr",  Mem_addr, 0);
      chk("rst_din",   Mem_din, 0);
      Reset = 1'b0;
      @(negedge Clk);

      // Basic load, bytes back-to-back
      base = wa.size(); dbase = n_done;
      start(6'd2);
      chk("basic_busy",  {31'd0, Busy}, 1);
      chk("basic_ready", {31'd0, Byte_ready}, 1);
      chk("basic_hold",  {31'd0, Cpu_hold}, 1);
      send_word(32'h2001_0008, 1'b0);
      send_word(32'h3402_000C, 1'b0);
      wait_done();
      chk("basic_hold_at_done", {31'd0, Cpu_hold}, 1);
      @(negedge Clk);
      chk("basic_hold_after", {31'd0, Cpu_hold}, 0);
      chk("basic_busy_after", {31'd0, Busy}, 0);
      chk("basic_nwr", 32'(wa.size() - base), 2);
      chk_write(base,     32'h0, 32'h2001_0008);
      chk_write(base + 1, 32'h4, 32'h3402_000C);
      chk("basic_ndone", 32'(n_done - dbase), 1);

      // Gaps between bytes, Byte_valid held high through WRITE/DONE
      base = wa.size();
      start(6'd1);
      send_word(32'hAD02_000A, 1'b1);
      Byte_in = 8'hFF; Byte_valid = 1'b1;
      wait_done();
      @(negedge Clk);
      Byte_valid = 1'b0;
      repeat (3) @(negedge Clk);
      chk("gap_nwr", 32'(wa.size() - base), 1);
      chk_write(base, 32'h0, 32'hAD02_000A);
      chk("gap_idle", {31'd0, Busy}, 0);

      // Illegal counts
      base = wa.size();
      start(6'd0);
      chk("err0_pulse", {31'd0, Err}, 1);
      chk("err0_busy",  {31'd0, Busy}, 0);
      @(negedge Clk);
      chk("err0_clear", {31'd0, Err}, 0);
      start(6'd33);
      chk("err33_pulse", {31'd0, Err}, 1);
      chk("err33_busy",  {31'd0, Busy}, 0);
      @(negedge Clk);
      chk("err33_clear", {31'd0, Err}, 0);
      chk("err_nwr", 32'(wa.size() - base), 0);

      // Full depth: 32 words
      base = wa.size();
      start(6'd32);
      chk("full_busy", {31'd0, Busy}, 1);
      for (int k = 0; k < 32; k++) send_word(32'h1000_0000 + 32'(k), 1'b0);
      wait_done();
      chk("full_last_addr", Mem_addr, 32'h7C);
      chk("full_nwr", 32'(wa.size() - base), 32);
      for (int k = 0; k < 32; k++) chk_write(base + k, 32'(4 * k), 32'h1000_0000 + 32'(k));
      @(negedge Clk);

      // Start while busy is ignored
      base = wa.size(); dbase = n_done;
      start(6'd2);
      send_word(32'hCAFE_0001, 1'b0);
      Start = 1'b1; Word_count = 6'd5;
      send_byte(8'hCA);
      send_byte(8'hFE);
      Start = 1'b0;
      send_byte(8'h00);
      send_byte(8'h02);
      wait_done();
      @(negedge Clk);
      repeat (3) @(negedge Clk);
      chk("busy_start_nwr", 32'(wa.size() - base), 2);
      chk_write(base,     32'h0, 32'hCAFE_0001);
      chk_write(base + 1, 32'h4, 32'hCAFE_0002);
      chk("busy_start_idle", {31'd0, Busy}, 0);
      chk("busy_start_ndone", 32'(n_done - dbase), 1);

      // Reset mid-word
      base = wa.size();
      start(6'd2);
      send_word(32'h1122_3344, 1'b0);
      send_byte(8'h55);
      send_byte(8'h66);
      Reset = 1'b1;
      #1;
      chk("mid_rst_hold",  {31'd0, Cpu_hold}, 0);
      chk("mid_rst_busy",  {31'd0, Busy}, 0);
      chk("mid_rst_ready", {31'd0, Byte_ready}, 0);
      chk("mid_rst_we",    {31'd0, Mem_we}, 0);
      chk("mid_rst_done",  {31'd0, Done}, 0);
      chk("mid_rst_err",   {31'd0, Err}, 0);
      chk("mid_rst_addr",  Mem_addr, 0);
      chk("mid_rst_din",   Mem_din, 0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      chk("mid_rst_nwr", 32'(wa.size() - base), 1);
      chk_write(base, 32'h0, 32'h1122_3344);
      base = wa.size();
      start(6'd1);
      send_word(32'h8D04_000A, 1'b0);
      wait_done();
      @(negedge Clk);
      chk("post_rst_nwr", 32'(wa.size() - base), 1);
      chk_write(base, 32'h0, 32'h8D04_000A);

      chk("hold_eq_busy", 32'(n_hold_bad), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory read by the single-cycle CPU's fetch stage. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written to consecutive word-aligned addresses starting at 0. While a load is in progress it holds the CPU off (`Cpu_hold`), and it signals completion with a one-cycle `Done` pulse.

## Interface
- `DEPTH_LOG2`, default 5: log2 of instruction memory depth in words (32 words).
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state immediately.
- `Start` in 1: begin a load session; sampled in IDLE only.
- `Word_count` in `DEPTH_LOG2+1`: number of words to load; sampled with `Start`; legal range is 1..2^`DEPTH_LOG2`.
- `Byte_in` in 8: stream data.
- `Byte_valid` in 1: `Byte_in` is valid.
- `Byte_ready` out 1: the loader accepts a byte this cycle.
- `Mem_we` out 1: instruction memory write enable.
- `Mem_addr` out 32: byte address, word aligned, equal to {zeros, word_idx, 2'b00}.
- `Mem_din` out 32: assembled instruction word.
- `Cpu_hold` out 1: high while a session is active; the CPU PC must not advance.
- `Busy` out 1: state is not IDLE.
- `Done` out 1: one-cycle pulse when the last word has been written.
- `Err` out 1: one-cycle pulse when `Start` arrives with an illegal `Word_count`.

## Operation
- **States:** IDLE, RECV, WRITE, DONE.
- **IDLE:**
  - On `Start`=1 with a legal count, latch the count, clear word_idx and byte_cnt, and go to RECV.
  - On `Start`=1 with count 0 or count > 2^`DEPTH_LOG2`, pulse `Err` and stay in IDLE.
- **RECV:**
  - `Byte_ready`=1.
  - On `Byte_valid`&`Byte_ready`, shift the byte into the word register. The first byte of a word goes to [31:24], the fourth to [7:0].
  - byte_cnt increments modulo 4. Acceptance of the 4th byte moves the FSM to WRITE.
- **WRITE:**
  - Lasts exactly one cycle.
  - `Byte_ready`=0, `Mem_we`=1, with `Mem_addr` and `Mem_din` stable.
  - If word_idx == count-1, go to DONE. Otherwise increment word_idx and go to RECV.
- **DONE:** Lasts one cycle with `Done`=1, then returns to IDLE.
- `Cpu_hold` = `Busy` = (state != IDLE).
- `Mem_we` is 0 in every state other than WRITE. `Mem_addr` and `Mem_din` hold their last values outside WRITE.
- `Start` is ignored outside IDLE.
- `Byte_valid` is ignored outside RECV, and no data is consumed.
- Any number of idle cycles between bytes (`Byte_valid`=0) is legal; the partial word is retained.

## Timing
- **Reset values:**
  - State = IDLE.
  - `Byte_ready`, `Mem_we`, `Cpu_hold`, `Busy`, `Done`, `Err` = 0.
  - `Mem_addr`, `Mem_din` = 0.
  - Internal counters = 0.
- **Reset mid-session:** The partial word is discarded. Words already written remain in memory, which this block does not own. `Cpu_hold` drops asynchronously.
- **Start:** `Start` sampled at edge E gives `Busy`=1 and `Byte_ready`=1 in the cycle after E.
- **Write latency:** The 4th byte accepted at edge N gives `Mem_we`=1 in cycle N..N+1. Memory captures the word at edge N+1.
- **Throughput:** One bubble per word (`Byte_ready`=0 during WRITE). Best case is 5 cycles per word.
- **Completion:** After the last WRITE, `Done`=1 for one cycle. `Busy` and `Cpu_hold` fall on the following edge, so the CPU may fetch from the cycle after `Done`.
- **Count width:** `Word_count`=2^`DEPTH_LOG2` (32) is legal. The last address is 0x7C.

## Test plan
- **Basic load:**
  - Stimulus: `Start`, count=2, bytes 20 01 00 08 34 02 00 0C sent back-to-back.
  - Required: writes (0x0, 0x20010008) then (0x4, 0x3402000C).
  - Required: `Done` pulses once; `Cpu_hold` is high from the cycle after `Start` through `Done`.
- **Backpressure and gaps:**
  - Stimulus: count=1, bytes AD 02 00 0A with random 0-3 cycle `Byte_valid` gaps, plus `Byte_valid` held high during WRITE.
  - Required: single write (0x0, 0xAD02000A); no byte is lost or duplicated.
- **Illegal count:**
  - Stimulus: `Start` with count=0, then with count=33.
  - Required: `Err` pulses each time; `Busy` stays 0; no `Mem_we`.
- **Full depth:**
  - Stimulus: count=32, word k = 0x1000_0000+k.
  - Required: 32 writes at addresses 0x00..0x7C in order; `Done` follows the write at 0x7C.
- **Start while busy:**
  - Stimulus: re-assert `Start` with count=5 during a count=2 session.
  - Required: ignored; exactly 2 writes occur.
- **Reset mid-word:**
  - Stimulus: count=2; after word 0 and 2 bytes of word 1, assert `Reset`.
  - Required: all outputs are 0 immediately; no further `Mem_we`.
  - Required: a new session with count=1, bytes 8D 04 00 0A, writes (0x0, 0x8D04000A).
